// File: rtl/pfc_seq_pkg.sv
// Shared types and bit positions for the PFC power-stage sequencer.
package pfc_seq_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRECHARGE = 3'd1,
        RELAY_ON  = 3'd2,
        RUN       = 3'd3,
        SHUTDOWN  = 3'd4,
        FAULT     = 3'd5
    } pfc_state_e;

    localparam int unsigned STAT_RUN   = 0;
    localparam int unsigned STAT_FAULT = 1;
    localparam int unsigned CMD_RUN    = 0;
    localparam int unsigned CMD_CLR    = 1;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pfc_seq_if.sv
// PIO command/status word plus the power-stage pins of the PFC sequencer.
interface pfc_seq_if;
    logic [1:0] cmd;
    logic       fault_n_in;
    logic       bus_ok_in;
    logic       relay_on;
    logic       gate_en;
    logic [1:0] status;

    modport master (
        output cmd, fault_n_in, bus_ok_in,
        input  relay_on, gate_en, status
    );

    modport slave (
        input  cmd, fault_n_in, bus_ok_in,
        output relay_on, gate_en, status
    );
endinterface

// File: rtl/pfc_seq_sync_db.sv
// Two-flop synchronizer with a low-level qualifier: low_o sets after DEPTH
// consecutive synced-low samples and clears on the first synced-high sample.
module pfc_seq_sync_db #(
    parameter int unsigned DEPTH   = 1,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic sync_o,
    output logic low_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          s1_q, s2_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          low_q, low_d;

    always_comb begin
        cnt_d = '0;
        low_d = 1'b0;
        if (!s2_q) begin
            cnt_d = (cnt_q == CW'(DEPTH)) ? cnt_q : cnt_q + 1'b1;
            low_d = (cnt_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q  <= RST_VAL;
            s2_q  <= RST_VAL;
            cnt_q <= '0;
            low_q <= 1'b0;
        end else begin
            s1_q  <= d_i;
            s2_q  <= s1_q;
            cnt_q <= cnt_d;
            low_q <= low_d;
        end
    end

    assign sync_o = s2_q;
    assign low_o  = low_q;

endmodule

// File: rtl/pfc_seq_ctrl.sv
// PFC power-stage enable sequencer: relay/gate ordering, fault latch, PIO status.
// Define PFC_SEQ_TIMEOUT_EN to fault out of PRECHARGE when bus-ok never arrives.
//
// state     | meaning
// IDLE      | relay open, gate off, waiting for run request
// PRECHARGE | bus charging through resistor, waiting min time and bus-ok
// RELAY_ON  | bypass relay closed, waiting for contacts to settle
// RUN       | relay closed, gate driver enabled
// SHUTDOWN  | gate off, relay held while switching stops
// FAULT     | everything off, latched until a qualified clear
module pfc_seq_ctrl
    import pfc_seq_pkg::*;
#(
    parameter int unsigned PRECHARGE_CYCLES    = 100000,
    parameter int unsigned RELAY_SETTLE_CYCLES = 5000,
    parameter int unsigned DEBOUNCE_CYCLES     = 8,
    parameter int unsigned TIMEOUT_CYCLES      = 500000
) (
    input  logic      clk,
    input  logic      reset_n,
    pfc_seq_if.slave  pfc
);

    localparam int unsigned CNT_MAX = max3(PRECHARGE_CYCLES, RELAY_SETTLE_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    pfc_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd1_q;
    logic             relay_q, gate_q;
    logic [1:0]       status_q;

    logic fault_db, bus_ok;
    logic fault_sync, bus_low;
    logic run_req, clr_pulse;
    logic pre_done, settle_done;
    logic unused_sync;

    pfc_seq_sync_db #(
        .DEPTH   (DEBOUNCE_CYCLES),
        .RST_VAL (1'b1)
    ) u_fault_db (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (pfc.fault_n_in),
        .sync_o  (fault_sync),
        .low_o   (fault_db)
    );

    pfc_seq_sync_db #(
        .DEPTH   (1),
        .RST_VAL (1'b0)
    ) u_bus_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (pfc.bus_ok_in),
        .sync_o  (bus_ok),
        .low_o   (bus_low)
    );

    assign unused_sync = fault_sync ^ bus_low;

    assign run_req     = pfc.cmd[CMD_RUN];
    assign clr_pulse   = pfc.cmd[CMD_CLR] & ~cmd1_q;
    assign pre_done    = (cnt_q >= CNT_W'(PRECHARGE_CYCLES - 1));
    assign settle_done = (cnt_q >= CNT_W'(RELAY_SETTLE_CYCLES - 1));

`ifdef PFC_SEQ_TIMEOUT_EN
    logic pre_timeout;
    assign pre_timeout = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        if (fault_db) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_req) state_d = PRECHARGE;
                end
                PRECHARGE: begin
                    if (!run_req)              state_d = IDLE;
                    else if (pre_done && bus_ok) state_d = RELAY_ON;
`ifdef PFC_SEQ_TIMEOUT_EN
                    else if (pre_timeout && !bus_ok) state_d = FAULT;
`endif
                end
                RELAY_ON: begin
                    if (!run_req)         state_d = SHUTDOWN;
                    else if (settle_done) state_d = RUN;
                end
                RUN: begin
                    // Bus collapse under load is treated as a fault even during a stop request.
                    if (!bus_ok)       state_d = FAULT;
                    else if (!run_req) state_d = SHUTDOWN;
                end
                SHUTDOWN: begin
                    if (settle_done) state_d = IDLE;
                end
                FAULT: begin
                    if (clr_pulse && !run_req) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd1_q   <= 1'b0;
            relay_q  <= 1'b0;
            gate_q   <= 1'b0;
            status_q <= '0;
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            cmd1_q               <= pfc.cmd[CMD_CLR];
            relay_q              <= (state_d inside {RELAY_ON, RUN, SHUTDOWN});
            gate_q               <= (state_d == RUN);
            status_q[STAT_RUN]   <= (state_d == RUN);
            status_q[STAT_FAULT] <= (state_d == FAULT);
        end
    end

    assign pfc.relay_on = relay_q;
    assign pfc.gate_en  = gate_q;
    assign pfc.status   = status_q;

endmodule

// File: tb/tb_pfc_seq_ctrl.sv
// Directed bench for pfc_seq_ctrl; outputs viewed as {relay_on, gate_en, status[1:0]}.
module tb_pfc_seq_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [3:0] outs;

    pfc_seq_if pfc ();

    pfc_seq_ctrl #(
        .PRECHARGE_CYCLES    (10),
        .RELAY_SETTLE_CYCLES (4),
        .DEBOUNCE_CYCLES     (3),
        .TIMEOUT_CYCLES      (20)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .pfc     (pfc)
    );

    always #5 clk = ~clk;

    assign outs = {pfc.relay_on, pfc.gate_en, pfc.status};

    task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // From IDLE with bus_ok synced high: 15 edges (0..14) reach RUN.
    task automatic start_run();
        pfc.cmd = 2'b01;
        step(15);
        check("start_run", outs, 4'b1101);
    endtask

    initial begin
        reset_n        = 1'b0;
        pfc.cmd        = 2'b00;
        pfc.fault_n_in = 1'b1;
        pfc.bus_ok_in  = 1'b1;
        step(3);
        check("reset", outs, 4'b0000);
        reset_n = 1'b1;
        step(3);
        check("idle", outs, 4'b0000);

        // normal start, cmd sampled at edge 0
        pfc.cmd = 2'b01;
        step(1);
        check("start_e0", outs, 4'b0000);
        step(9);
        check("start_e9", outs, 4'b0000);
        step(1);
        check("start_e10_relay", outs, 4'b1000);
        step(3);
        check("start_e13", outs, 4'b1000);
        step(1);
        check("start_e14_run", outs, 4'b1101);

        // normal stop
        pfc.cmd = 2'b00;
        step(1);
        check("stop_gate_off", outs, 4'b1000);
        step(3);
        check("stop_relay_held", outs, 4'b1000);
        step(1);
        check("stop_idle", outs, 4'b0000);

        // fault glitch of two cycles is filtered
        start_run();
        pfc.fault_n_in = 1'b0;
        step(2);
        pfc.fault_n_in = 1'b1;
        step(8);
        check("glitch_ignored", outs, 4'b1101);

        // held fault: outputs drop at edge 6 after the fall
        pfc.fault_n_in = 1'b0;
        step(5);
        check("fault_e5", outs, 4'b1101);
        step(1);
        check("fault_e6", outs, 4'b0010);
        pfc.cmd = 2'b10;
        step(2);
        check("clr_pin_low", outs, 4'b0010);
        pfc.fault_n_in = 1'b1;
        step(4);
        pfc.cmd = 2'b00;
        step(1);
        check("fault_no_pulse", outs, 4'b0010);
        pfc.cmd = 2'b10;
        step(1);
        check("fault_cleared", outs, 4'b0000);

        // clear pulse coinciding with fault_db, then clear with run held
        pfc.cmd = 2'b00;
        step(1);
        pfc.fault_n_in = 1'b0;
        step(5);
        pfc.cmd = 2'b10;
        step(1);
        check("clr_same_cycle", outs, 4'b0010);
        step(2);
        check("clr_same_latched", outs, 4'b0010);
        pfc.fault_n_in = 1'b1;
        step(4);
        pfc.cmd = 2'b00;
        step(1);
        pfc.cmd = 2'b11;
        step(2);
        check("clr_with_run", outs, 4'b0010);
        pfc.cmd = 2'b00;
        step(1);
        pfc.cmd = 2'b10;
        step(1);
        check("clr_after_run", outs, 4'b0000);
        pfc.cmd = 2'b00;
        step(1);

        // bus loss in RUN
        start_run();
        pfc.bus_ok_in = 1'b0;
        step(2);
        check("bus_loss_e2", outs, 4'b1101);
        step(1);
        check("bus_loss_e3", outs, 4'b0010);
        pfc.bus_ok_in = 1'b1;
        pfc.cmd = 2'b00;
        step(3);
        pfc.cmd = 2'b10;
        step(1);
        check("bus_loss_clr", outs, 4'b0000);
        pfc.cmd = 2'b00;
        step(1);

        // precharge without bus-ok
        pfc.bus_ok_in = 1'b0;
        step(3);
        pfc.cmd = 2'b01;
`ifdef PFC_SEQ_TIMEOUT_EN
        step(20);
        check("timeout_e19", outs, 4'b0000);
        step(1);
        check("timeout_e20", outs, 4'b0010);
        pfc.bus_ok_in = 1'b1;
        pfc.cmd = 2'b00;
        step(1);
        pfc.cmd = 2'b10;
        step(1);
        check("timeout_clr", outs, 4'b0000);
        start_run();
`else
        step(1001);
        check("wait_e1000", outs, 4'b0000);
        pfc.bus_ok_in = 1'b1;
        step(2);
        check("bus_late_e2", outs, 4'b0000);
        step(1);
        check("bus_late_relay", outs, 4'b1000);
        step(4);
        check("bus_late_run", outs, 4'b1101);
`endif

        // reset mid-RUN with run request held
        reset_n = 1'b0;
        step(1);
        check("reset_mid_run", outs, 4'b0000);
        reset_n = 1'b1;
        step(10);
        check("restart_e10", outs, 4'b0000);
        step(1);
        check("restart_relay", outs, 4'b1000);
        step(4);
        check("restart_run", outs, 4'b1101);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
